// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan-bus capture monitor: segment
// patterns, blank code, LED bit positions, FSM states and one-hot helpers.
package seg7_pkg;

  // Segment patterns on LED[6:0] = {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit code stored for a dark digit
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // LED bus bit positions
  localparam int LED_SEG_MSB = 6;
  localparam int LED_DP_BIT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // True when exactly one digit-select line is active
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Index of the active line of a one-hot select
  function automatic logic [1:0] onehot_index4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder: legal digit 0-9, blank, or illegal.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       legal_o,
  output logic       blank_o
);

  // Pattern lookup; anything not listed is an illegal glyph
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    digit_o = 4'h0;
    legal_o = 1'b1;
    blank_o = 1'b0;
    case (seg_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_BLANK: begin
        digit_o = BLANK_CODE;
        legal_o = 1'b0;
        blank_o = 1'b1;
      end
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receiving end of a multiplexed 7-segment bus: recovers the four scanned
// digits, their decimal points, a 0-59 seconds value, and flags bad glyphs.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE         = 2,
  parameter int TIMEOUT_MAX    = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit SA_ACTIVE_LOW  = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  LED,
  input  logic [3:0]  SA,
  output logic [15:0] DIGITS,
  output logic [3:0]  DVALID,
  output logic [3:0]  DP,
  output logic        FRAME,
  output logic        ERR,
  output logic [5:0]  SEC60,
  output logic        SEC60_VALID
);

  localparam int CNT_W = $clog2(SETTLE) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_MAX);

  logic [7:0]       led_q, lat_led_q;
  logic [3:0]       sa_q, lat_sa_q;
  state_e           state_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      digits_q;
  logic [3:0]       dvalid_q, dp_q, seen_q;
  logic             frame_q, err_q, sec_upd_q, sec_valid_q;
  logic [5:0]       sec_q;
  logic [TO_W-1:0]  to_q;

  logic             sa_onehot, sa_same, led_same, restart, capture, cap_ok, timeout_hit;
  logic             sec_ok, d1_blank;
  logic [3:0]       seen_nxt, d0, d1, d1_val;
  logic [5:0]       sec_d;
  logic [TO_W-1:0]  to_d;
  logic [3:0]       dec_digit;
  logic             dec_legal, dec_blank;

  seg7_decode u_decode (
    .seg_i   (lat_led_q[LED_SEG_MSB:0]),
    .digit_o (dec_digit),
    .legal_o (dec_legal),
    .blank_o (dec_blank)
  );

  // Input stage: normalise polarity and register the bus once
  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!RESET) begin
      led_q <= 8'h00;
      sa_q  <= 4'h0;
    end else begin
      led_q <= SEG_ACTIVE_LOW ? ~LED : LED;
      sa_q  <= SA_ACTIVE_LOW ? ~SA : SA;
    end
  end

  // Settle/capture decisions, timeout counting and seconds arithmetic
  always_comb begin
    sa_onehot   = is_onehot4(sa_q);
    sa_same     = (sa_q == lat_sa_q);
    led_same    = (led_q == lat_led_q);
    restart     = sa_onehot && ((state_q == ST_IDLE) || !sa_same || !led_same);
    capture     = (state_q == ST_SETTLE) && sa_same && led_same && (cnt_q == CNT_LAST);
    cap_ok      = dec_legal || dec_blank;
    seen_nxt    = seen_q | (4'b0001 << sel_q);
    to_d        = capture ? '0 : ((to_q == TO_LIMIT) ? TO_LIMIT : to_q + TO_W'(1));
    timeout_hit = !capture && (to_d == TO_LIMIT);
    d0          = digits_q[3:0];
    d1          = digits_q[7:4];
    d1_blank    = (d1 == BLANK_CODE);
    d1_val      = d1_blank ? 4'd0 : d1;
    sec_ok      = (dvalid_q[1:0] == 2'b11) && (d0 <= 4'd9) && ((d1 <= 4'd5) || d1_blank);
    sec_d       = {2'b00, d1_val} * 6'd10 + {2'b00, d0};
  end

  // Scan FSM: wait for a one-hot select, demand SETTLE stable cycles, then hold
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      sel_q     <= 2'd0;
      cnt_q     <= '0;
      lat_led_q <= 8'h00;
      lat_sa_q  <= 4'h0;
    end else if (restart) begin
      state_q   <= ST_SETTLE;
      cnt_q     <= '0;
      sel_q     <= onehot_index4(sa_q);
      lat_sa_q  <= sa_q;
      lat_led_q <= led_q;
    end else if (!sa_onehot) begin
      state_q <= ST_IDLE;
    end else if (state_q == ST_SETTLE) begin
      if (capture) state_q <= ST_HOLD;
      else         cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Digit store, frame tracking, error pulse and inactivity timeout
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      digits_q  <= 16'h0000;
      dvalid_q  <= 4'h0;
      dp_q      <= 4'h0;
      seen_q    <= 4'h0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
      sec_upd_q <= 1'b0;
      to_q      <= '0;
    end else begin
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
      sec_upd_q <= capture && !sel_q[1];
      to_q      <= to_d;
      if (capture) begin
        if (cap_ok) begin
          digits_q[{sel_q, 2'b00} +: 4] <= dec_digit;
          dvalid_q[sel_q]               <= 1'b1;
          dp_q[sel_q]                   <= lat_led_q[LED_DP_BIT];
          if (&seen_nxt) begin
            frame_q <= 1'b1;
            seen_q  <= 4'h0;
          end else begin
            seen_q <= seen_nxt;
          end
        end else begin
          err_q           <= 1'b1;
          dvalid_q[sel_q] <= 1'b0;
        end
      end else if (timeout_hit) begin
        dvalid_q <= 4'h0;
        seen_q   <= 4'h0;
      end
    end
  end

  // Seconds value refreshed the cycle after digit 0 or 1 is captured
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sec_q       <= 6'd0;
      sec_valid_q <= 1'b0;
    end else begin
      if (sec_upd_q) begin
        if (sec_ok) begin
          sec_q       <= sec_d;
          sec_valid_q <= 1'b1;
        end else begin
          sec_valid_q <= 1'b0;
        end
      end
      if (timeout_hit) sec_valid_q <= 1'b0;
    end
  end

  assign DIGITS      = digits_q;
  assign DVALID      = dvalid_q;
  assign DP          = dp_q;
  assign FRAME       = frame_q;
  assign ERR         = err_q;
  assign SEC60       = sec_q;
  assign SEC60_VALID = sec_valid_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scenarios plus randomized scan
// transactions, all checked against a digit-level reference model.
module tb_seg7_scan_capture;

  localparam int SETTLE      = 2;
  localparam int TIMEOUT_MAX = 1024;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [7:0]  LED = 8'h00;
  logic [3:0]  SA = 4'h0;
  logic [15:0] DIGITS;
  logic [3:0]  DVALID, DP;
  logic        FRAME, ERR, SEC60_VALID;
  logic [5:0]  SEC60;

  int total = 0;
  int bad = 0;
  int frame_cnt = 0;
  int err_cnt = 0;

  // Reference model state: what a perfect observer of the display would know
  logic [3:0] m_dig [4];
  logic       m_val [4];
  logic       m_dp  [4];
  logic       m_seen[4];
  logic [5:0] m_sec;
  logic       m_secv;
  int         m_frame = 0;
  int         m_err = 0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg7_scan_capture #(
    .SETTLE         (SETTLE),
    .TIMEOUT_MAX    (TIMEOUT_MAX),
    .SEG_ACTIVE_LOW (1'b0),
    .SA_ACTIVE_LOW  (1'b0)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .LED         (LED),
    .SA          (SA),
    .DIGITS      (DIGITS),
    .DVALID      (DVALID),
    .DP          (DP),
    .FRAME       (FRAME),
    .ERR         (ERR),
    .SEC60       (SEC60),
    .SEC60_VALID (SEC60_VALID)
  );

  always #5 CLK = ~CLK;

  // Pulse monitor, sampled shortly after each rising edge
  always begin
    @(posedge CLK);
    #2;
    if (FRAME) frame_cnt++;
    if (ERR)   err_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_dig[i]  = 4'h0;
      m_val[i]  = 1'b0;
      m_dp[i]   = 1'b0;
      m_seen[i] = 1'b0;
    end
    m_sec  = 6'd0;
    m_secv = 1'b0;
  endfunction

  // A digit shown steadily long enough: apply the display rules to the model
  function automatic void model_capture(input int sel, input logic [7:0] led);
    int v;
    int d0, d1;
    v = -1;
    for (int i = 0; i < 10; i++) if (seg_tab[i] == led[6:0]) v = i;
    if (led[6:0] == 7'h00) v = 15;
    if (v >= 0) begin
      m_dig[sel]  = 4'(v);
      m_val[sel]  = 1'b1;
      m_dp[sel]   = led[7];
      m_seen[sel] = 1'b1;
      if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
        m_frame++;
        for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
      end
    end else begin
      m_err++;
      m_val[sel] = 1'b0;
    end
    if (sel < 2) begin
      d0 = int'(m_dig[0]);
      d1 = int'(m_dig[1]);
      if (m_val[0] && m_val[1] && d0 <= 9 && (d1 <= 5 || d1 == 15)) begin
        m_secv = 1'b1;
        m_sec  = 6'(((d1 == 15) ? 0 : d1) * 10 + d0);
      end else begin
        m_secv = 1'b0;
      end
    end
  endfunction

  function automatic void model_timeout();
    for (int i = 0; i < 4; i++) begin
      m_val[i]  = 1'b0;
      m_seen[i] = 1'b0;
    end
    m_secv = 1'b0;
  endfunction

  function automatic logic [30:0] exp_vec();
    logic [15:0] d;
    logic [3:0]  v, p;
    for (int i = 0; i < 4; i++) begin
      d[i*4 +: 4] = m_dig[i];
      v[i]        = m_val[i];
      p[i]        = m_dp[i];
    end
    return {d, v, p, m_secv, m_sec};
  endfunction

  // Show one digit for h cycles, then dark bus for g cycles
  task automatic drive_txn(input int sel, input logic [7:0] led, input int h, input int g);
    SA  = 4'b0001 << sel;
    LED = led;
    repeat (h) @(negedge CLK);
    if (g > 0) begin
      SA  = 4'h0;
      LED = 8'h00;
      repeat (g) @(negedge CLK);
    end
    if (h >= SETTLE + 1) model_capture(sel, led);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if ({DIGITS, DVALID, DP, SEC60_VALID, SEC60, FRAME, ERR} !== 33'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0",
               {DIGITS, DVALID, DP, SEC60_VALID, SEC60, FRAME, ERR});
    end
    RESET = 1'b1;
    model_reset();
    @(negedge CLK);
  endtask

  task automatic test_latency();
    SA  = 4'b0001;
    LED = 8'h3F;
    repeat (SETTLE + 1) @(negedge CLK);
    total++;
    if (DVALID !== 4'b0000) begin
      bad++;
      $display("FAIL latency_early: got DVALID=%b want 0000", DVALID);
    end
    @(negedge CLK);
    model_capture(0, 8'h3F);
    total++;
    if ({DIGITS, DVALID, DP, SEC60_VALID, SEC60} !== exp_vec() || DVALID !== 4'b0001 || FRAME !== 1'b0) begin
      bad++;
      $display("FAIL latency_capture: got %h frame=%b want %h frame=0",
               {DIGITS, DVALID, DP, SEC60_VALID, SEC60}, FRAME, exp_vec());
    end
    SA  = 4'h0;
    LED = 8'h00;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_scan();
    int f0;
    f0 = frame_cnt;
    drive_txn(0, 8'h5B, 4, 0);
    drive_txn(1, 8'h4F, 4, 0);
    drive_txn(2, 8'h7D, 4, 0);
    drive_txn(3, 8'h00, 4, 2);
    total++;
    if (DIGITS !== 16'hF632 || DVALID !== 4'b1111 || SEC60 !== 6'd32 || SEC60_VALID !== 1'b1) begin
      bad++;
      $display("FAIL scan_values: got digits=%h dvalid=%b sec=%0d v=%b want F632 1111 32 1",
               DIGITS, DVALID, SEC60, SEC60_VALID);
    end
    total++;
    if (frame_cnt - f0 !== 1 || {DIGITS, DVALID, DP, SEC60_VALID, SEC60} !== exp_vec()) begin
      bad++;
      $display("FAIL scan_frame: got frames=%0d state=%h want frames=1 state=%h",
               frame_cnt - f0, {DIGITS, DVALID, DP, SEC60_VALID, SEC60}, exp_vec());
    end
  endtask

  task automatic test_glitch();
    drive_txn(1, 8'h5B, 1, 0);
    drive_txn(0, 8'h5B, 4, 2);
    total++;
    if (DIGITS[7:4] !== 4'h3 || DVALID[1] !== 1'b1 ||
        {DIGITS, DVALID, DP, SEC60_VALID, SEC60} !== exp_vec()) begin
      bad++;
      $display("FAIL glitch_reject: got %h want %h (d1=3)",
               {DIGITS, DVALID, DP, SEC60_VALID, SEC60}, exp_vec());
    end
  endtask

  task automatic test_illegal();
    int e0;
    e0 = err_cnt;
    drive_txn(0, 8'h49, 3, 2);
    total++;
    if (err_cnt - e0 !== 1 || DVALID[0] !== 1'b0 || DIGITS[3:0] !== 4'h2 ||
        SEC60_VALID !== 1'b0 || SEC60 !== 6'd32) begin
      bad++;
      $display("FAIL illegal_pattern: got errs=%0d dv0=%b d0=%h secv=%b sec=%0d want 1 0 2 0 32",
               err_cnt - e0, DVALID[0], DIGITS[3:0], SEC60_VALID, SEC60);
    end
    total++;
    if ({DIGITS, DVALID, DP, SEC60_VALID, SEC60} !== exp_vec() || frame_cnt !== m_frame) begin
      bad++;
      $display("FAIL illegal_model: got %h frames=%0d want %h frames=%0d",
               {DIGITS, DVALID, DP, SEC60_VALID, SEC60}, frame_cnt, exp_vec(), m_frame);
    end
  endtask

  task automatic test_random();
    int sel, pick, h;
    logic [7:0] led;
    for (int n = 0; n < 60; n++) begin
      sel  = int'($urandom_range(0, 3));
      pick = int'($urandom_range(0, 11));
      if (pick < 10)       led[6:0] = seg_tab[pick];
      else if (pick == 10) led[6:0] = 7'h00;
      else                 led[6:0] = 7'($urandom);
      led[7] = 1'($urandom);
      h = int'($urandom_range(1, 5));
      drive_txn(sel, led, h, 2);
      total++;
      if ({DIGITS, DVALID, DP, SEC60_VALID, SEC60} !== exp_vec() ||
          frame_cnt !== m_frame || err_cnt !== m_err) begin
        bad++;
        $display("FAIL random_txn %0d (sel=%0d led=%h hold=%0d): got %h f=%0d e=%0d want %h f=%0d e=%0d",
                 n, sel, led, h, {DIGITS, DVALID, DP, SEC60_VALID, SEC60}, frame_cnt, err_cnt,
                 exp_vec(), m_frame, m_err);
      end
    end
  endtask

  task automatic test_timeout();
    drive_txn(1, 8'h07, 4, 2);
    SA  = 4'b0001;
    LED = 8'h06;
    repeat (SETTLE + 2) @(negedge CLK);
    model_capture(0, 8'h06);
    SA  = 4'h0;
    LED = 8'h00;
    @(negedge CLK);
    total++;
    if (SEC60_VALID !== 1'b0 || {DIGITS, DVALID, DP, SEC60_VALID, SEC60} !== exp_vec()) begin
      bad++;
      $display("FAIL sec60_out_of_range: got %h want %h (secv=0)",
               {DIGITS, DVALID, DP, SEC60_VALID, SEC60}, exp_vec());
    end
    repeat (TIMEOUT_MAX - 2) @(negedge CLK);
    total++;
    if (DVALID[1:0] !== 2'b11) begin
      bad++;
      $display("FAIL timeout_early: got DVALID=%b want xx11 one cycle before limit", DVALID);
    end
    @(negedge CLK);
    model_timeout();
    total++;
    if (DVALID !== 4'b0000 || {DIGITS, DVALID, DP, SEC60_VALID, SEC60} !== exp_vec()) begin
      bad++;
      $display("FAIL timeout_limit: got %h want %h (dvalid=0000)",
               {DIGITS, DVALID, DP, SEC60_VALID, SEC60}, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    SA  = 4'b0001;
    LED = 8'h86;
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    total++;
    if ({DIGITS, DVALID, DP, SEC60_VALID, SEC60, FRAME, ERR} !== 33'd0) begin
      bad++;
      $display("FAIL reset_mid: got %h want 0",
               {DIGITS, DVALID, DP, SEC60_VALID, SEC60, FRAME, ERR});
    end
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (SETTLE + 1) @(negedge CLK);
    total++;
    if (DVALID !== 4'b0000) begin
      bad++;
      $display("FAIL reset_resettle_early: got DVALID=%b want 0000", DVALID);
    end
    @(negedge CLK);
    model_capture(0, 8'h86);
    total++;
    if (DIGITS !== 16'h0001 || DP !== 4'b0001 ||
        {DIGITS, DVALID, DP, SEC60_VALID, SEC60} !== exp_vec()) begin
      bad++;
      $display("FAIL reset_resettle_capture: got %h want %h",
               {DIGITS, DVALID, DP, SEC60_VALID, SEC60}, exp_vec());
    end
    SA  = 4'h0;
    LED = 8'h00;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_scan();
    test_glitch();
    test_illegal();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
